// File: rtl/tpu_uart_pkg.sv
// Shared definitions for the TPU UART command protocol, used by both the
// host-side sequencer and the TPU-side command controller.
package tpu_uart_pkg;

  localparam logic [7:0] CMD_WR_WEIGHTS   = 8'h01;
  localparam logic [7:0] CMD_WR_ACTS      = 8'h02;
  localparam logic [7:0] CMD_EXECUTE      = 8'h03;
  localparam logic [7:0] CMD_READ_STATUS  = 8'h04;
  localparam logic [7:0] CMD_READ_RESULT  = 8'h05;
  localparam logic [7:0] CMD_SIGNAL_READY = 8'h06;

  localparam logic [7:0] UART_ACK = 8'hAA;

  typedef enum logic [1:0] {
    RSP_OK      = 2'd0,
    RSP_NAK     = 2'd1,
    RSP_TIMEOUT = 2'd2,
    RSP_BAD_CMD = 2'd3
  } rsp_err_t;

  typedef enum logic [2:0] {
    HOST_IDLE,
    HOST_SEND_CMD,
    HOST_SEND_PAYLOAD,
    HOST_WAIT_RSP,
    HOST_DONE
  } host_state_t;

  function automatic logic [3:0] rsp_len(input logic [7:0] cmd);
    return (cmd == CMD_READ_RESULT) ? 4'd8 : 4'd1;
  endfunction

  function automatic logic cmd_known(input logic [7:0] cmd);
    return (cmd >= CMD_WR_WEIGHTS) && (cmd <= CMD_SIGNAL_READY);
  endfunction

endpackage

// File: rtl/rsp_timeout_timer.sv
// Saturating idle-cycle counter for reply bytes; flags expiry on the clock
// edge where the count would reach TIMEOUT_CYCLES.
module rsp_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count >= LIMIT - 1'b1);

endmodule

// File: rtl/uart_host_sequencer.sv
// Host-side initiator: sends one opcode (plus payload for weight/activation
// writes) over a byte stream and collects/checks the device reply.
module uart_host_sequencer
  import tpu_uart_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [31:0] req_payload,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rsp_valid,
  output logic [1:0]  rsp_err,
  output logic [7:0]  rsp_status,
  output logic [63:0] rsp_data,
  output logic        stray_rx,
  output logic        busy
);

  host_state_t state, state_next;
  logic [7:0]  cmd_q;
  logic [31:0] payload_q;
  logic [2:0]  cnt;
  logic [63:0] data_acc;
  logic        rx_prev;
  logic        ready_en;
  logic        rx_edge;
  logic        last_byte;
  logic        expired;

  assign rx_edge   = rx_valid && !rx_prev;
  assign last_byte = ({1'b0, cnt} == (rsp_len(cmd_q) - 4'd1));
  assign req_ready = (state == HOST_IDLE) && ready_en;
  assign busy      = (state != HOST_IDLE);
  assign rsp_valid = (state == HOST_DONE);

  rsp_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   ((state != HOST_WAIT_RSP) || rx_edge),
    .enable  (state == HOST_WAIT_RSP),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HOST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    case (state)
      HOST_IDLE: begin
        if (req_valid && req_ready) begin
          state_next = cmd_known(req_cmd) ? HOST_SEND_CMD : HOST_DONE;
        end
      end
      HOST_SEND_CMD: begin
        tx_valid = 1'b1;
        tx_data  = cmd_q;
        if (tx_ready) begin
          state_next = ((cmd_q == CMD_WR_WEIGHTS) || (cmd_q == CMD_WR_ACTS)) ?
                       HOST_SEND_PAYLOAD : HOST_WAIT_RSP;
        end
      end
      HOST_SEND_PAYLOAD: begin
        tx_valid = 1'b1;
        tx_data  = payload_q[{cnt[1:0], 3'b000} +: 8];
        if (tx_ready && (cnt == 3'd3)) begin
          state_next = HOST_WAIT_RSP;
        end
      end
      HOST_WAIT_RSP: begin
        // A byte arriving on the expiry edge takes priority over the timeout.
        if (rx_edge) begin
          if (last_byte) begin
            state_next = HOST_DONE;
          end
        end else if (expired) begin
          state_next = HOST_DONE;
        end
      end
      HOST_DONE: state_next = HOST_IDLE;
      default:   state_next = HOST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q      <= 8'h00;
      payload_q  <= 32'h0;
      cnt        <= 3'd0;
      data_acc   <= 64'h0;
      rx_prev    <= 1'b0;
      ready_en   <= 1'b0;
      stray_rx   <= 1'b0;
      rsp_err    <= RSP_OK;
      rsp_status <= 8'h00;
      rsp_data   <= 64'h0;
    end else begin
      ready_en <= 1'b1;
      rx_prev  <= rx_valid;
      if (rx_edge && (state != HOST_WAIT_RSP)) begin
        stray_rx <= 1'b1;
      end
      case (state)
        HOST_IDLE: begin
          if (req_valid && req_ready) begin
            cmd_q     <= req_cmd;
            payload_q <= req_payload;
            cnt       <= 3'd0;
            data_acc  <= 64'h0;
            if (!cmd_known(req_cmd)) begin
              rsp_err <= RSP_BAD_CMD;
            end
          end
        end
        HOST_SEND_PAYLOAD: begin
          if (tx_valid && tx_ready) begin
            cnt <= (cnt == 3'd3) ? 3'd0 : cnt + 3'd1;
          end
        end
        HOST_WAIT_RSP: begin
          if (rx_edge) begin
            cnt <= cnt + 3'd1;
            data_acc[{cnt, 3'b000} +: 8] <= rx_data;
            if (last_byte) begin
              case (cmd_q)
                CMD_READ_STATUS: begin
                  rsp_status <= rx_data;
                  rsp_err    <= RSP_OK;
                end
                CMD_READ_RESULT: begin
                  rsp_data <= {rx_data, data_acc[55:0]};
                  rsp_err  <= RSP_OK;
                end
                default: rsp_err <= (rx_data == UART_ACK) ? RSP_OK : RSP_NAK;
              endcase
            end
          end else if (expired) begin
            rsp_err  <= RSP_TIMEOUT;
            rsp_data <= data_acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_host_sequencer.sv
// Directed self-checking bench for uart_host_sequencer with a short reply
// timeout so the abort path can be exercised quickly.
module tb_uart_host_sequencer;

  localparam int unsigned TIMEOUT = 50;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_cmd;
  logic [31:0] req_payload;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rsp_valid;
  logic [1:0]  rsp_err;
  logic [7:0]  rsp_status;
  logic [63:0] rsp_data;
  logic        stray_rx;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  uart_host_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_cmd     (req_cmd),
    .req_payload (req_payload),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rsp_valid   (rsp_valid),
    .rsp_err     (rsp_err),
    .rsp_status  (rsp_status),
    .rsp_data    (rsp_data),
    .stray_rx    (stray_rx),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetOutputs(input string ctx);
    checkOutput({ctx, ".req_ready"},  64'(req_ready),  64'(0));
    checkOutput({ctx, ".tx_valid"},   64'(tx_valid),   64'(0));
    checkOutput({ctx, ".tx_data"},    64'(tx_data),    64'(0));
    checkOutput({ctx, ".rsp_valid"},  64'(rsp_valid),  64'(0));
    checkOutput({ctx, ".rsp_err"},    64'(rsp_err),    64'(0));
    checkOutput({ctx, ".rsp_status"}, 64'(rsp_status), 64'(0));
    checkOutput({ctx, ".rsp_data"},   rsp_data,        64'(0));
    checkOutput({ctx, ".stray_rx"},   64'(stray_rx),   64'(0));
    checkOutput({ctx, ".busy"},       64'(busy),       64'(0));
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input logic [31:0] payload);
    req_cmd     = cmd;
    req_payload = payload;
    req_valid   = 1'b1;
    for (int i = 0; i < 20 && !req_ready; i++) tick();
    checkOutput("req_ready_wait", 64'(req_ready), 64'(1));
    tick();
    req_valid = 1'b0;
  endtask

  task automatic expectTx(input string tag, input logic [39:0] bytes, input int n);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s.tx_valid[%0d]", tag, i), 64'(tx_valid), 64'(1));
      checkOutput($sformatf("%s.tx_data[%0d]", tag, i), 64'(tx_data), 64'(bytes[8*i +: 8]));
      tick();
    end
    checkOutput({tag, ".tx_idle"}, 64'(tx_valid), 64'(0));
  endtask

  task automatic replyByte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic expectResponse(input string tag, input logic [1:0] err);
    checkOutput({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(1));
    checkOutput({tag, ".rsp_err"},   64'(rsp_err),   64'(err));
    tick();
    checkOutput({tag, ".rsp_pulse"}, 64'(rsp_valid), 64'(0));
    checkOutput({tag, ".ready"},     64'(req_ready), 64'(1));
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: bench did not complete, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] result;
    int          n;

    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_cmd     = 8'h00;
    req_payload = 32'h0;
    tx_ready    = 1'b1;
    rx_data     = 8'h00;
    rx_valid    = 1'b0;
    tick();
    tick();
    checkResetOutputs("reset");
    rst_n = 1'b1;
    checkOutput("ready_at_release", 64'(req_ready), 64'(0));
    tick();
    checkOutput("ready_after_release", 64'(req_ready), 64'(1));

    $display("[TB] write weights with ACK");
    applyStimulus(8'h01, 32'h04030201);
    checkOutput("wr.busy", 64'(busy), 64'(1));
    expectTx("wr", 40'h04_03_02_01_01, 5);
    replyByte(8'hAA);
    expectResponse("wr", 2'd0);

    $display("[TB] read results, 8 reply bytes");
    applyStimulus(8'h05, 32'h0);
    expectTx("rd", 40'h05, 1);
    result = 64'h9ABCDEF0_12345678;
    for (int i = 0; i < 8; i++) begin
      replyByte(result[8*i +: 8]);
      if (i < 7) tick();
    end
    checkOutput("rd.rsp_data", rsp_data, 64'h9ABCDEF0_12345678);
    expectResponse("rd", 2'd0);

    $display("[TB] read status with transmitter stall");
    tx_ready = 1'b0;
    applyStimulus(8'h04, 32'h0);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("stall.tx_valid[%0d]", i), 64'(tx_valid), 64'(1));
      checkOutput($sformatf("stall.tx_data[%0d]", i), 64'(tx_data), 64'(8'h04));
      tick();
    end
    tx_ready = 1'b1;
    tick();
    checkOutput("stall.tx_done", 64'(tx_valid), 64'(0));
    replyByte(8'h13);
    checkOutput("stall.rsp_status", 64'(rsp_status), 64'(8'h13));
    expectResponse("stall", 2'd0);

    $display("[TB] execute with NAK reply");
    applyStimulus(8'h03, 32'h0);
    expectTx("nak", 40'h03, 1);
    replyByte(8'h55);
    checkOutput("nak.status_held", 64'(rsp_status), 64'(8'h13));
    expectResponse("nak", 2'd1);

    $display("[TB] unknown opcodes");
    applyStimulus(8'h09, 32'h0);
    checkOutput("bad09.tx_valid", 64'(tx_valid), 64'(0));
    expectResponse("bad09", 2'd3);
    applyStimulus(8'h07, 32'h0);
    checkOutput("bad07.tx_valid", 64'(tx_valid), 64'(0));
    expectResponse("bad07", 2'd3);
    applyStimulus(8'h00, 32'h0);
    checkOutput("bad00.tx_valid", 64'(tx_valid), 64'(0));
    expectResponse("bad00", 2'd3);

    $display("[TB] read results with truncated reply");
    applyStimulus(8'h05, 32'h0);
    expectTx("to", 40'h05, 1);
    replyByte(8'h78);
    tick();
    replyByte(8'h56);
    tick();
    replyByte(8'h34);
    n = 0;
    do begin
      tick();
      n++;
    end while (!rsp_valid && n < 200);
    checkOutput("to.latency", 64'(n), 64'(TIMEOUT));
    expectResponse("to", 2'd2);
    checkOutput("to.no_stray", 64'(stray_rx), 64'(0));
    replyByte(8'h11);
    checkOutput("to.stray_rx", 64'(stray_rx), 64'(1));
    tick();

    $display("[TB] reset during payload transfer");
    applyStimulus(8'h02, 32'hDDCCBBAA);
    tick();
    checkOutput("rst.payload_byte0", 64'(tx_data), 64'(8'hAA));
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("rst.rsp_valid", 64'(rsp_valid), 64'(0));
    applyStimulus(8'h06, 32'h0);
    expectTx("ready", 40'h06, 1);
    replyByte(8'hAA);
    expectResponse("ready", 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_host_sequencer.md
# uart_host_sequencer

Host-side initiator for the TPU UART command protocol: accepts one command request at a time, serializes the opcode and payload bytes onto a byte-stream transmitter, and collects and checks the device's reply bytes (ACK, status or 8-byte results). It sits between a test/host controller and a `uart_tx`/`uart_rx` pair whose serial lines connect to the TPU-side command controller. Used for board-to-board bring-up and as a synthesizable driver in system benches.

## Interface
- `TIMEOUT_CYCLES`, 1_000_000: idle clocks allowed between reply bytes before aborting.
- `clk` in 1: clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_cmd` in 8: opcode 0x01–0x06.
- `req_payload` in 32: weight/activation bytes, byte 0 = bits [7:0].
- `tx_data` out 8: byte to transmitter.
- `tx_valid` out 1: byte offered; held until accepted.
- `tx_ready` in 1: transmitter accepts when `tx_valid && tx_ready`.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one byte consumed per rising edge (high now, low previous cycle).
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_err` out 2: 0 OK, 1 NAK, 2 TIMEOUT, 3 BAD_CMD.
- `rsp_status` out 8: status byte from 0x04.
- `rsp_data` out 64: results from 0x05, first byte received in [7:0].
- `stray_rx` out 1: sticky; set when a byte arrives outside WAIT_RSP. Cleared only by reset.
- `busy` out 1: not IDLE.

## Operation
- States: IDLE, SEND_CMD, SEND_PAYLOAD, WAIT_RSP, DONE.
- IDLE: on `req_valid && req_ready`, latch cmd/payload, clear byte counter.
  - Opcode outside 0x01–0x06: go to DONE with `rsp_err`=3; no bytes sent.
  - Otherwise go to SEND_CMD.
- SEND_CMD: `tx_valid`=1, `tx_data`=opcode. On accept:
  - 0x01/0x02: go to SEND_PAYLOAD.
  - Other opcodes: go to WAIT_RSP.
- SEND_PAYLOAD: send payload bytes [7:0], [15:8], [23:16], [31:24] in order, one per accept. After the 4th accept, go to WAIT_RSP.
- WAIT_RSP: expected reply length is 1 byte for 0x01/02/03/04/06 and 8 bytes for 0x05.
  - 0x01/02/03/06: byte 0xAA → OK; any other byte → NAK (`rsp_err`=1).
  - 0x04: store the byte in `rsp_status`; result is OK.
  - 0x05: shift bytes into `rsp_data` LSB-first; after the 8th byte, result is OK.
  - Go to DONE after the last expected byte.
- Timeout: counter clears on entry to WAIT_RSP and on every received byte. When it reaches `TIMEOUT_CYCLES`, go to DONE with `rsp_err`=2. Any partial `rsp_data` is kept as-is.
- DONE: `rsp_valid`=1 for one cycle, then IDLE. `rsp_*` outputs hold until the next DONE.
- 0x05 with `rsp_err`≠0: `rsp_data` is don't-care.

## Timing
- Reset values: `req_ready`=0, then 1 the first cycle after reset deassertion. All other outputs are 0: `tx_valid`, `tx_data`, `rsp_valid`, `rsp_err`, `rsp_status`, `rsp_data`, `stray_rx`, `busy`. State is IDLE.
- Request accept to `tx_valid` rising: 1 cycle.
- After an accept, the next byte is offered on the following cycle, so back-to-back bytes are possible when `tx_ready` stays high.
- `tx_data` is stable while `tx_valid && !tx_ready`.
- Last reply byte edge to `rsp_valid`: 1 cycle. `rsp_valid` to `req_ready`: 1 cycle.
- Bad opcode: request accept to `rsp_valid` is 1 cycle.
- `rx_valid` edge in the same cycle the timeout count hits its limit: the byte wins and the counter clears.
- `rx_valid` edges in SEND_CMD/SEND_PAYLOAD (device replying early) set `stray_rx`. The byte is dropped; the state machine waits in WAIT_RSP and can time out.
- Reset asserted mid-transaction: everything returns to reset values immediately; no `rsp_valid` is produced for the aborted request.
- Timeout counter width is `$clog2(TIMEOUT_CYCLES+1)`; it saturates and does not wrap.

## Structure
- Shared package `tpu_uart_pkg`:
  - Opcode constants CMD_WR_WEIGHTS…CMD_SIGNAL_READY (0x01–0x06).
  - `UART_ACK`=8'hAA.
  - `rsp_err_t` enum.
  - Host state enum.
  - Reply-length function `rsp_len(cmd)`.
- The TPU-side controller imports the same opcode constants.
- One sub-module: `rsp_timeout_timer` (clear, enable, `expired` output).
- `uart_tx`/`uart_rx` are instantiated by the parent, not inside this block.

## Test plan
- 0x01, payload 0x04030201, `tx_ready` always 1, device replies 0xAA → tx bytes 01,01,02,03,04; then `rsp_valid` with `rsp_err`=0.
- 0x05, device replies 78,56,34,12,F0,DE,BC,9A → `rsp_data`=0x9ABCDEF0_12345678, `rsp_err`=0.
- 0x04, `tx_ready` held low for 10 cycles then high, reply 0x13 → `tx_data` stable throughout the stall; `rsp_status`=0x13.
- 0x03 with reply 0x55 → `rsp_err`=1; `req_cmd`=0x09 → `rsp_err`=3, no `tx_valid`, `rsp_valid` one cycle after accept.
- `TIMEOUT_CYCLES`=50, 0x05 with only 3 reply bytes → `rsp_err`=2 exactly 50 cycles after the 3rd byte; a later byte sets `stray_rx`.
- `rst_n` pulsed low during SEND_PAYLOAD → all outputs return to reset values; a new 0x06 request completes OK.
